seg7_scan_driver: RTL and testbench

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_scan_driver.sv | 139 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// 7-segment scan driver: time-multiplexes DIGITS hex nibbles onto one seg/dp bus with a one-hot anode select.
// Registered outputs, 1-cycle latency from holding registers; no backpressure, load is accepted every cycle.
module seg7_scan_driver #(
    parameter int DIGITS        = 4,
    parameter int DIV           = 1000,
    parameter int AN_ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  lz_blank,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = $clog2(DIGITS);
    localparam logic [CW-1:0]     CNT_LAST = CW'(DIV - 1);
    localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{AN_ACTIVE_LOW != 0}};

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1111110;
            4'h1:    s = 7'b0110000;
            4'h2:    s = 7'b1101101;
            4'h3:    s = 7'b1111001;
            4'h4:    s = 7'b0110011;
            4'h5:    s = 7'b1011011;
            4'h6:    s = 7'b1011111;
            4'h7:    s = 7'b1110000;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1111011;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b0011111;
            4'hC:    s = 7'b1001110;
            4'hD:    s = 7'b0111101;
            4'hE:    s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] hold_data_q, hold_data_d;
    logic [DIGITS-1:0]   hold_dp_q, hold_dp_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                frame_q, frame_d;
    logic                adv;
    logic [DIGITS-1:0]   blank;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_blank;

    always_comb begin
        adv         = en && (cnt_q == CNT_LAST);
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        if (en) begin
            cnt_d = adv ? '0 : cnt_q + 1'b1;
        end
        if (adv) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        hold_data_d = load ? data  : hold_data_q;
        hold_dp_d   = load ? dp_in : hold_dp_q;
    end

    // blank[k]: digit k and every digit above it hold zero; digit 0 is never blanked
    always_comb begin
        blank = '0;
        blank[DIGITS-1] = (hold_data_q[4*DIGITS-4 +: 4] == 4'h0);
        for (int k = DIGITS - 2; k >= 1; k--) begin
            blank[k] = blank[k+1] && (hold_data_q[4*k +: 4] == 4'h0);
        end
    end

    // Output regs follow the index being entered this edge, so a load that coincides
    // with an advance shows the old value on the new digit and the new value one cycle later.
    always_comb begin
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_d == IW'(k)) begin
                cur_nib   = hold_data_q[4*k +: 4];
                cur_dp    = hold_dp_q[k];
                cur_blank = lz_blank && blank[k];
            end
        end
    end

    always_comb begin
        seg_d   = '0;
        dp_d    = 1'b0;
        an_d    = AN_OFF;
        frame_d = adv && (idx_q == IDX_LAST);
        if (en) begin
            seg_d = cur_blank ? 7'b0000000 : hex_to_seg(cur_nib);
            dp_d  = cur_dp;
            an_d  = AN_OFF ^ (DIGITS'(1) << idx_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            hold_data_q <= '0;
            hold_dp_q   <= '0;
            seg_q       <= '0;
            dp_q        <= 1'b0;
            an_q        <= AN_OFF;
            frame_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            hold_data_q <= hold_data_d;
            hold_dp_q   <= hold_dp_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
            frame_q     <= frame_d;
        end
    end

    assign seg   = seg_q;
    assign dp    = dp_q;
    assign an    = an_q;
    assign frame = frame_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: three instances (DIV=2, DIV=3, DIV=2 active-low anodes) share stimulus.
module tb_seg7_scan_driver;
    logic        clk = 1'b0;
    logic        rst, en, load, lz_blank;
    logic [15:0] data;
    logic [3:0]  dp_in;
    logic [6:0]  seg_a, seg_b, seg_c;
    logic        dp_a, dp_b, dp_c;
    logic [3:0]  an_a, an_b, an_c;
    logic        frame_a, frame_b, frame_c;
    int          pass_cnt = 0;
    int          chk_cnt = 0;
    logic [6:0]  seg_tbl [16];

    always #5 clk = ~clk;

    seg7_scan_driver #(.DIGITS(4), .DIV(2), .AN_ACTIVE_LOW(0)) u_a (
        .clk(clk), .rst(rst), .en(en), .load(load), .data(data), .dp_in(dp_in),
        .lz_blank(lz_blank), .seg(seg_a), .dp(dp_a), .an(an_a), .frame(frame_a));
    seg7_scan_driver #(.DIGITS(4), .DIV(3), .AN_ACTIVE_LOW(0)) u_b (
        .clk(clk), .rst(rst), .en(en), .load(load), .data(data), .dp_in(dp_in),
        .lz_blank(lz_blank), .seg(seg_b), .dp(dp_b), .an(an_b), .frame(frame_b));
    seg7_scan_driver #(.DIGITS(4), .DIV(2), .AN_ACTIVE_LOW(1)) u_c (
        .clk(clk), .rst(rst), .en(en), .load(load), .data(data), .dp_in(dp_in),
        .lz_blank(lz_blank), .seg(seg_c), .dp(dp_c), .an(an_c), .frame(frame_c));

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; load = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    // Reset, capture d/p with the scan stopped, then enable; the next step is scan edge k=1.
    task automatic start_scan(input logic [15:0] d, input logic [3:0] p);
        do_reset();
        data = d; dp_in = p; load = 1'b1;
        step(1);
        load = 1'b0; en = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; load = 1'b1; data = 16'hFFFF; dp_in = 4'hF; lz_blank = 1'b0;
        step(2);
        chk_cnt++; if ({seg_a, dp_a, an_a, frame_a} !== 12'h000) $display("FAIL reset_outputs got=%b exp=%b", {seg_a, dp_a, an_a, frame_a}, 12'h000); else pass_cnt++;
        chk_cnt++; if (an_c !== 4'b1111) $display("FAIL reset_an_active_low got=%b exp=%b", an_c, 4'b1111); else pass_cnt++;
        chk_cnt++; if ({seg_b, an_b, frame_b} !== 12'h000) $display("FAIL reset_outputs_div3 got=%b exp=%b", {seg_b, an_b, frame_b}, 12'h000); else pass_cnt++;
        rst = 1'b0; load = 1'b0;
        step(1);
        chk_cnt++; if ({seg_a, dp_a, an_a} !== {7'b1111110, 1'b0, 4'b0001}) $display("FAIL reset_cleared_hold got=%b exp=%b", {seg_a, dp_a, an_a}, {7'b1111110, 1'b0, 4'b0001}); else pass_cnt++;
        chk_cnt++; if (an_c !== 4'b1110) $display("FAIL polarity_d0 got=%b exp=%b", an_c, 4'b1110); else pass_cnt++;
        step(1);
        chk_cnt++; if (an_c !== 4'b1101) $display("FAIL polarity_d1 got=%b exp=%b", an_c, 4'b1101); else pass_cnt++;
        chk_cnt++; if ({seg_a, an_a} !== {7'b1111110, 4'b0010}) $display("FAIL reset_d1 got=%b exp=%b", {seg_a, an_a}, {7'b1111110, 4'b0010}); else pass_cnt++;
    endtask

    task automatic test_decode();
        lz_blank = 1'b0;
        start_scan(16'h0123, 4'h0);
        step(1);
        chk_cnt++; if ({seg_a, dp_a, an_a} !== {7'b1111001, 1'b0, 4'b0001}) $display("FAIL decode_d0 got=%b exp=%b", {seg_a, dp_a, an_a}, {7'b1111001, 1'b0, 4'b0001}); else pass_cnt++;
        step(1);
        chk_cnt++; if ({seg_a, an_a} !== {7'b1101101, 4'b0010}) $display("FAIL decode_d1 got=%b exp=%b", {seg_a, an_a}, {7'b1101101, 4'b0010}); else pass_cnt++;
        step(2);
        chk_cnt++; if ({seg_a, an_a} !== {7'b0110000, 4'b0100}) $display("FAIL decode_d2 got=%b exp=%b", {seg_a, an_a}, {7'b0110000, 4'b0100}); else pass_cnt++;
        step(2);
        chk_cnt++; if ({seg_a, an_a, frame_a} !== {7'b1111110, 4'b1000, 1'b0}) $display("FAIL decode_d3 got=%b exp=%b", {seg_a, an_a, frame_a}, {7'b1111110, 4'b1000, 1'b0}); else pass_cnt++;
        step(2);
        chk_cnt++; if ({seg_a, an_a, frame_a} !== {7'b1111001, 4'b0001, 1'b1}) $display("FAIL decode_wrap_frame got=%b exp=%b", {seg_a, an_a, frame_a}, {7'b1111001, 4'b0001, 1'b1}); else pass_cnt++;
        step(1);
        chk_cnt++; if (frame_a !== 1'b0) $display("FAIL decode_frame_width got=%b exp=%b", frame_a, 1'b0); else pass_cnt++;
    endtask

    task automatic test_all_nibbles();
        lz_blank = 1'b0;
        for (int v = 0; v < 16; v++) begin
            start_scan(16'(v), 4'h0);
            step(1);
            chk_cnt++; if ({seg_a, an_a} !== {seg_tbl[v], 4'b0001}) $display("FAIL nibble_%0h got=%b exp=%b", v, {seg_a, an_a}, {seg_tbl[v], 4'b0001}); else pass_cnt++;
        end
    endtask

    task automatic test_suppress();
        lz_blank = 1'b1;
        start_scan(16'h0050, 4'b0100);
        step(1);
        chk_cnt++; if ({seg_a, dp_a, an_a} !== {7'b1111110, 1'b0, 4'b0001}) $display("FAIL lz50_d0 got=%b exp=%b", {seg_a, dp_a, an_a}, {7'b1111110, 1'b0, 4'b0001}); else pass_cnt++;
        step(1);
        chk_cnt++; if ({seg_a, dp_a, an_a} !== {7'b1011011, 1'b0, 4'b0010}) $display("FAIL lz50_d1 got=%b exp=%b", {seg_a, dp_a, an_a}, {7'b1011011, 1'b0, 4'b0010}); else pass_cnt++;
        step(2);
        chk_cnt++; if ({seg_a, dp_a, an_a} !== {7'b0000000, 1'b1, 4'b0100}) $display("FAIL lz50_d2_dp got=%b exp=%b", {seg_a, dp_a, an_a}, {7'b0000000, 1'b1, 4'b0100}); else pass_cnt++;
        step(2);
        chk_cnt++; if ({seg_a, dp_a, an_a} !== {7'b0000000, 1'b0, 4'b1000}) $display("FAIL lz50_d3 got=%b exp=%b", {seg_a, dp_a, an_a}, {7'b0000000, 1'b0, 4'b1000}); else pass_cnt++;
        start_scan(16'h0000, 4'h0);
        step(1);
        chk_cnt++; if ({seg_a, an_a} !== {7'b1111110, 4'b0001}) $display("FAIL lz00_d0 got=%b exp=%b", {seg_a, an_a}, {7'b1111110, 4'b0001}); else pass_cnt++;
        step(1);
        chk_cnt++; if ({seg_a, an_a} !== {7'b0000000, 4'b0010}) $display("FAIL lz00_d1 got=%b exp=%b", {seg_a, an_a}, {7'b0000000, 4'b0010}); else pass_cnt++;
        step(2);
        chk_cnt++; if ({seg_a, an_a} !== {7'b0000000, 4'b0100}) $display("FAIL lz00_d2 got=%b exp=%b", {seg_a, an_a}, {7'b0000000, 4'b0100}); else pass_cnt++;
        step(2);
        chk_cnt++; if ({seg_a, an_a} !== {7'b0000000, 4'b1000}) $display("FAIL lz00_d3 got=%b exp=%b", {seg_a, an_a}, {7'b0000000, 4'b1000}); else pass_cnt++;
        lz_blank = 1'b0;
    endtask

    task automatic test_load_advance();
        start_scan(16'h1111, 4'h0);
        step(1);
        chk_cnt++; if ({seg_a, an_a} !== {7'b0110000, 4'b0001}) $display("FAIL ldadv_before got=%b exp=%b", {seg_a, an_a}, {7'b0110000, 4'b0001}); else pass_cnt++;
        load = 1'b1; data = 16'h2222;
        step(1);
        load = 1'b0;
        chk_cnt++; if ({seg_a, an_a} !== {7'b0110000, 4'b0010}) $display("FAIL ldadv_old_value got=%b exp=%b", {seg_a, an_a}, {7'b0110000, 4'b0010}); else pass_cnt++;
        step(1);
        chk_cnt++; if ({seg_a, an_a} !== {7'b1101101, 4'b0010}) $display("FAIL ldadv_new_value got=%b exp=%b", {seg_a, an_a}, {7'b1101101, 4'b0010}); else pass_cnt++;
    endtask

    task automatic test_enable_reset();
        start_scan(16'h0123, 4'h0);
        step(4);
        chk_cnt++; if ({seg_a, an_a} !== {7'b0110000, 4'b0100}) $display("FAIL en_at_d2 got=%b exp=%b", {seg_a, an_a}, {7'b0110000, 4'b0100}); else pass_cnt++;
        en = 1'b0; load = 1'b1; data = 16'h4567;
        for (int i = 0; i < 5; i++) begin
            step(1);
            load = 1'b0;
            chk_cnt++; if ({seg_a, dp_a, an_a, frame_a} !== 12'h000) $display("FAIL en_off_cycle%0d got=%b exp=%b", i, {seg_a, dp_a, an_a, frame_a}, 12'h000); else pass_cnt++;
        end
        chk_cnt++; if (an_c !== 4'b1111) $display("FAIL en_off_an_active_low got=%b exp=%b", an_c, 4'b1111); else pass_cnt++;
        en = 1'b1;
        step(1);
        chk_cnt++; if ({seg_a, an_a} !== {7'b1011011, 4'b0100}) $display("FAIL en_resume_d2 got=%b exp=%b", {seg_a, an_a}, {7'b1011011, 4'b0100}); else pass_cnt++;
        step(1);
        chk_cnt++; if ({seg_a, an_a} !== {7'b0110011, 4'b1000}) $display("FAIL en_resume_d3 got=%b exp=%b", {seg_a, an_a}, {7'b0110011, 4'b1000}); else pass_cnt++;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk_cnt++; if ({seg_a, dp_a, an_a, frame_a} !== 12'h000) $display("FAIL midscan_reset got=%b exp=%b", {seg_a, dp_a, an_a, frame_a}, 12'h000); else pass_cnt++;
        step(1);
        chk_cnt++; if ({seg_a, an_a} !== {7'b1111110, 4'b0001}) $display("FAIL restart_d0 got=%b exp=%b", {seg_a, an_a}, {7'b1111110, 4'b0001}); else pass_cnt++;
    endtask

    task automatic test_timing();
        int waited = 0;
        int frames = 0;
        logic [3:0] exp_an;
        logic       exp_fr;
        start_scan(16'h0123, 4'h0);
        while (frame_b !== 1'b1 && waited < 40) begin
            step(1);
            waited++;
        end
        chk_cnt++; if (frame_b !== 1'b1) $display("FAIL timing_first_frame got=%b exp=%b after %0d cycles", frame_b, 1'b1, waited); else pass_cnt++;
        for (int j = 0; j <= 24; j++) begin
            if (j > 0) step(1);
            exp_an = 4'b0001 << ((j / 3) % 4);
            exp_fr = ((j % 12) == 0);
            if (frame_b === 1'b1) frames++;
            chk_cnt++; if ({an_b, frame_b} !== {exp_an, exp_fr}) $display("FAIL timing_cycle%0d got=%b exp=%b", j, {an_b, frame_b}, {exp_an, exp_fr}); else pass_cnt++;
        end
        chk_cnt++; if (frames !== 3) $display("FAIL timing_frame_count got=%0d exp=%0d", frames, 3); else pass_cnt++;
    endtask

    initial begin
        seg_tbl = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
        rst = 1'b1; en = 1'b0; load = 1'b0; lz_blank = 1'b0; data = '0; dp_in = '0;
        @(negedge clk);
        test_reset();
        test_decode();
        test_all_nibbles();
        test_suppress();
        test_load_advance();
        test_enable_reset();
        test_timing();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
